sram_2rw_param: RTL and testbench

Parametrised dual-port (2RW) behavioural SRAM model for simulation and macro-stub use in the ASAP7 flow; successor to the fixed 16x16 2RW macro model. Adds configurable width/depth, per-lane write masks, an optional output pipeline register, a post-reset memory-clear sequencer, and defined, flagged behaviour for same-address collisions between ports. Both ports share one clock; memory contents are not reset, but are zeroed by the clear sequencer when it is enabled.

---
 rtl/sram_pkg.sv | 36 +++
 rtl/sram_read_pipe.sv | 50 +++++
 rtl/sram_2rw_param.sv | 150 +++++++++++++++
 tb/tb_sram_2rw_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared types and helpers for the parametrised 2RW SRAM model:
//                clear-sequencer state encoding, per-lane write merge and
//                parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Clear sequencer states, explicitly one bit wide.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Merge of two masked writes for one bit of a lane. Port 1 has priority
    // wherever both ports enable the lane; otherwise the enabling port's
    // data is taken, and an unenabled lane keeps its stored value.
    function automatic logic merge_bit(
        input logic old_bit,
        input logic en1,
        input logic d1,
        input logic en2,
        input logic d2
    );
        return en1 ? d1 : (en2 ? d2 : old_bit);
    endfunction

    // Legal parameter combinations: whole lanes per word, at least two words.
    function automatic bit params_ok(input int dw, input int mg, input int depth);
        return (mg > 0) && ((dw % mg) == 0) && (depth >= 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_read_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sram_read_pipe
//  Description : Per-port read path. Holds the last read word and optionally
//                adds one output register stage for 2-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_read_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_re,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_hold;

    // Capture the addressed word on a read; keep it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (i_re) begin
            r_hold <= i_rdata;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_out;

            // Extra register stage trailing the hold register by one edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out <= '0;
                end else begin
                    r_out <= r_hold;
                end
            end

            assign o_rdata = r_out;
        end else begin : g_no_out_reg
            assign o_rdata = r_hold;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_2rw_param.sv
`default_nettype none
// ============================================================================
//  Module      : sram_2rw_param
//  Description : Parametrised dual-port (2RW) behavioural SRAM with per-lane
//                write masks, optional output register, post-reset clear
//                sequencer and flagged same-address collisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_2rw_param
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int MASK_GRAN      = 8,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             A1,
    input  logic [ADDR_WIDTH-1:0]             A2,
    input  logic                              CSB1,
    input  logic                              CSB2,
    input  logic                              WEB1,
    input  logic                              WEB2,
    input  logic                              OEB1,
    input  logic                              OEB2,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0]   M1,
    input  logic [DATA_WIDTH/MASK_GRAN-1:0]   M2,
    input  logic [DATA_WIDTH-1:0]             I1,
    input  logic [DATA_WIDTH-1:0]             I2,
    output logic [DATA_WIDTH-1:0]             O1,
    output logic [DATA_WIDTH-1:0]             O2,
    output logic                              busy,
    output logic                              collision
);

    localparam int                  c_LANES = DATA_WIDTH / MASK_GRAN;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (!params_ok(DATA_WIDTH, MASK_GRAN, DEPTH)) begin : g_param_check
            $error("sram_2rw_param: DATA_WIDTH must be a multiple of MASK_GRAN and DEPTH >= 2");
        end
    endgenerate

    clr_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_collision;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_re1, w_re2, w_we1, w_we2;
    logic                  w_ok1, w_ok2, w_same;
    logic [DATA_WIDTH-1:0] w_bm1, w_bm2;
    logic [DATA_WIDTH-1:0] w_old1, w_old2;
    logic [DATA_WIDTH-1:0] w_new1, w_new2;

    assign busy      = (r_state == CLEAR);
    assign collision = r_collision;

    assign w_re1 = ~CSB1 & ~OEB1 & ~busy;
    assign w_re2 = ~CSB2 & ~OEB2 & ~busy;
    assign w_we1 = ~CSB1 & ~WEB1 & ~busy;
    assign w_we2 = ~CSB2 & ~WEB2 & ~busy;

    // Out-of-range addresses never touch the array and read back as zero.
    assign w_ok1  = ({1'b0, A1} < c_DEPTH);
    assign w_ok2  = ({1'b0, A2} < c_DEPTH);
    assign w_same = (A1 == A2);
    assign w_old1 = w_ok1 ? r_mem[A1] : '0;
    assign w_old2 = w_ok2 ? r_mem[A2] : '0;

    generate
        for (genvar l = 0; l < c_LANES; l++) begin : g_lane
            assign w_bm1[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{M1[l] & w_we1}};
            assign w_bm2[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{M2[l] & w_we2}};
        end

        // Each port's new word folds in the other port's lanes when both hit
        // the same address, so both writers store the identical merged word.
        for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
            assign w_new1[b] = merge_bit(w_old1[b], w_bm1[b], I1[b], w_bm2[b] & w_same, I2[b]);
            assign w_new2[b] = merge_bit(w_old2[b], w_bm1[b] & w_same, I1[b], w_bm2[b], I2[b]);
        end
    endgenerate

    // Array update: zero fill while clearing, otherwise masked port writes.
    always_ff @(posedge clock) begin
        if (!reset && (r_state == CLEAR)) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            if (w_we1 && w_ok1) begin
                r_mem[A1] <= w_new1;
            end
            if (w_we2 && w_ok2) begin
                r_mem[A2] <= w_new2;
            end
        end
    end

    // Clear sequencer: walks every word once after reset, then idles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            if (r_clr_addr == c_LAST) begin
                r_state    <= READY;
                r_clr_addr <= '0;
            end else begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    // Flag same-address accesses by both ports where at least one writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_same & (w_we1 | w_we2) & (w_re1 | w_we1) & (w_re2 | w_we2);
        end
    end

    sram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_read_pipe1 (
        .clk     (clock),
        .rst     (reset),
        .i_re    (w_re1),
        .i_rdata (w_old1),
        .o_rdata (O1)
    );

    sram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_read_pipe2 (
        .clk     (clock),
        .rst     (reset),
        .i_re    (w_re2),
        .i_rdata (w_old2),
        .o_rdata (O2)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_2rw_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_2rw_param
//  Description : Directed self-checking bench. dut_a: 16x16, OUT_REG=0, with
//                clear. dut_b: 12x16, OUT_REG=1, no clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_2rw_param;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [3:0]  a_A1, a_A2, b_A1, b_A2;
    logic        a_CSB1, a_CSB2, a_WEB1, a_WEB2, a_OEB1, a_OEB2;
    logic        b_CSB1, b_CSB2, b_WEB1, b_WEB2, b_OEB1, b_OEB2;
    logic [1:0]  a_M1, a_M2, b_M1, b_M2;
    logic [15:0] a_I1, a_I2, a_O1, a_O2, b_I1, b_I2, b_O1, b_O2;
    logic        a_busy, a_col, b_busy, b_col;

    int checks   = 0;
    int failures = 0;

    sram_2rw_param #(
        .DATA_WIDTH(16), .DEPTH(16), .MASK_GRAN(8), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clock(clock), .reset(reset), .A1(a_A1), .A2(a_A2),
        .CSB1(a_CSB1), .CSB2(a_CSB2), .WEB1(a_WEB1), .WEB2(a_WEB2),
        .OEB1(a_OEB1), .OEB2(a_OEB2), .M1(a_M1), .M2(a_M2),
        .I1(a_I1), .I2(a_I2), .O1(a_O1), .O2(a_O2),
        .busy(a_busy), .collision(a_col)
    );

    sram_2rw_param #(
        .DATA_WIDTH(16), .DEPTH(12), .MASK_GRAN(8), .OUT_REG(1), .CLEAR_ON_RESET(0)
    ) dut_b (
        .clock(clock), .reset(reset), .A1(b_A1), .A2(b_A2),
        .CSB1(b_CSB1), .CSB2(b_CSB2), .WEB1(b_WEB1), .WEB2(b_WEB2),
        .OEB1(b_OEB1), .OEB2(b_OEB2), .M1(b_M1), .M2(b_M2),
        .I1(b_I1), .I2(b_I2), .O1(b_O1), .O2(b_O2),
        .busy(b_busy), .collision(b_col)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic a_idle;
        a_CSB1 = 1'b1; a_WEB1 = 1'b1; a_OEB1 = 1'b1; a_A1 = '0; a_M1 = 2'b11; a_I1 = '0;
        a_CSB2 = 1'b1; a_WEB2 = 1'b1; a_OEB2 = 1'b1; a_A2 = '0; a_M2 = 2'b11; a_I2 = '0;
    endtask

    task automatic b_idle;
        b_CSB1 = 1'b1; b_WEB1 = 1'b1; b_OEB1 = 1'b1; b_A1 = '0; b_M1 = 2'b11; b_I1 = '0;
        b_CSB2 = 1'b1; b_WEB2 = 1'b1; b_OEB2 = 1'b1; b_A2 = '0; b_M2 = 2'b11; b_I2 = '0;
    endtask

    task automatic a_p1(input logic we, input logic re, input logic [3:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        a_CSB1 = 1'b0; a_WEB1 = ~we; a_OEB1 = ~re; a_A1 = a; a_I1 = d; a_M1 = m;
    endtask

    task automatic a_p2(input logic we, input logic re, input logic [3:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        a_CSB2 = 1'b0; a_WEB2 = ~we; a_OEB2 = ~re; a_A2 = a; a_I2 = d; a_M2 = m;
    endtask

    task automatic b_p1(input logic we, input logic re, input logic [3:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        b_CSB1 = 1'b0; b_WEB1 = ~we; b_OEB1 = ~re; b_A1 = a; b_I1 = d; b_M1 = m;
    endtask

    task automatic b_p2(input logic we, input logic re, input logic [3:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        b_CSB2 = 1'b0; b_WEB2 = ~we; b_OEB2 = ~re; b_A2 = a; b_I2 = d; b_M2 = m;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_idle();
        b_idle();
        tick();
        tick();
        checks++; if (a_O1 !== 16'h0000) begin failures++; $display("FAIL reset_a_O1 got %h exp %h", a_O1, 16'h0000); end
        checks++; if (a_O2 !== 16'h0000) begin failures++; $display("FAIL reset_a_O2 got %h exp %h", a_O2, 16'h0000); end
        checks++; if (a_col !== 1'b0) begin failures++; $display("FAIL reset_a_col got %b exp 0", a_col); end
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL reset_a_busy got %b exp 1", a_busy); end
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL reset_b_busy got %b exp 0", b_busy); end
        checks++; if (b_O1 !== 16'h0000) begin failures++; $display("FAIL reset_b_O1 got %h exp %h", b_O1, 16'h0000); end
    endtask

    task automatic test_clear_busy;
        int n;
        reset = 1'b0;
        // Write held through the whole busy window must be ignored.
        a_p1(1'b1, 1'b0, 4'd0, 16'hBEEF, 2'b11);
        // dut_b has no clear and must accept a write straight away.
        b_p2(1'b1, 1'b0, 4'd11, 16'hB0B0, 2'b11);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) b_idle();
        end while (a_busy && n < 40);
        checks++; if (n !== 16) begin failures++; $display("FAIL clear_busy_cycles got %0d exp 16", n); end
        a_idle();
        a_p1(1'b0, 1'b1, 4'd0, 16'h0, 2'b11);
        a_p2(1'b0, 1'b1, 4'd15, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h0000) begin failures++; $display("FAIL clear_ignored_write got %h exp %h", a_O1, 16'h0000); end
        checks++; if (a_O2 !== 16'h0000) begin failures++; $display("FAIL clear_last_word got %h exp %h", a_O2, 16'h0000); end
        a_idle();
    endtask

    task automatic test_write_read;
        a_p1(1'b1, 1'b0, 4'd3, 16'h1234, 2'b11);
        tick();
        a_p1(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        a_p2(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h1234) begin failures++; $display("FAIL rw_port1 got %h exp %h", a_O1, 16'h1234); end
        checks++; if (a_O2 !== 16'h1234) begin failures++; $display("FAIL rw_port2_visible got %h exp %h", a_O2, 16'h1234); end
        a_idle();
        tick();
        checks++; if (a_O1 !== 16'h1234) begin failures++; $display("FAIL rw_hold got %h exp %h", a_O1, 16'h1234); end
        // Same-port read during write returns the old word.
        a_p1(1'b1, 1'b1, 4'd3, 16'h4321, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h1234) begin failures++; $display("FAIL rw_read_first got %h exp %h", a_O1, 16'h1234); end
        a_p1(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h4321) begin failures++; $display("FAIL rw_after_rfw got %h exp %h", a_O1, 16'h4321); end
        a_idle();
    endtask

    task automatic test_mask_merge;
        a_p1(1'b1, 1'b0, 4'd5, 16'hAAAA, 2'b01);
        a_p2(1'b1, 1'b0, 4'd5, 16'h5555, 2'b11);
        tick();
        checks++; if (a_col !== 1'b1) begin failures++; $display("FAIL merge_collision got %b exp 1", a_col); end
        a_idle();
        a_p1(1'b0, 1'b1, 4'd5, 16'h0, 2'b11);
        tick();
        checks++; if (a_col !== 1'b0) begin failures++; $display("FAIL merge_collision_pulse got %b exp 0", a_col); end
        checks++; if (a_O1 !== 16'h55AA) begin failures++; $display("FAIL merge_word got %h exp %h", a_O1, 16'h55AA); end
        a_p1(1'b1, 1'b0, 4'd5, 16'hFFFF, 2'b10);
        tick();
        a_p1(1'b0, 1'b1, 4'd5, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'hFFAA) begin failures++; $display("FAIL mask_upper_lane got %h exp %h", a_O1, 16'hFFAA); end
        a_idle();
    endtask

    task automatic test_read_write_cross;
        a_p1(1'b1, 1'b0, 4'd7, 16'h1111, 2'b11);
        tick();
        a_p1(1'b0, 1'b1, 4'd7, 16'h0, 2'b11);
        a_p2(1'b1, 1'b0, 4'd7, 16'h2222, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h1111) begin failures++; $display("FAIL cross_old_word got %h exp %h", a_O1, 16'h1111); end
        checks++; if (a_col !== 1'b1) begin failures++; $display("FAIL cross_collision got %b exp 1", a_col); end
        a_idle();
        a_p1(1'b0, 1'b1, 4'd7, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h2222) begin failures++; $display("FAIL cross_new_word got %h exp %h", a_O1, 16'h2222); end
        checks++; if (a_col !== 1'b0) begin failures++; $display("FAIL cross_collision_clr got %b exp 0", a_col); end
        a_idle();
    endtask

    task automatic test_no_collision;
        a_p1(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        a_p2(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        tick();
        checks++; if (a_col !== 1'b0) begin failures++; $display("FAIL rr_collision got %b exp 0", a_col); end
        checks++; if (a_O2 !== 16'h4321) begin failures++; $display("FAIL rr_port2 got %h exp %h", a_O2, 16'h4321); end
        a_p1(1'b1, 1'b0, 4'd8, 16'h0808, 2'b11);
        a_p2(1'b1, 1'b0, 4'd9, 16'h0909, 2'b11);
        tick();
        checks++; if (a_col !== 1'b0) begin failures++; $display("FAIL ww_diff_collision got %b exp 0", a_col); end
        a_p1(1'b0, 1'b1, 4'd8, 16'h0, 2'b11);
        a_p2(1'b0, 1'b1, 4'd9, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h0808) begin failures++; $display("FAIL ww_diff_p1 got %h exp %h", a_O1, 16'h0808); end
        checks++; if (a_O2 !== 16'h0909) begin failures++; $display("FAIL ww_diff_p2 got %h exp %h", a_O2, 16'h0909); end
        a_idle();
    endtask

    task automatic test_out_reg_range;
        b_p1(1'b1, 1'b0, 4'd3, 16'h1234, 2'b11);
        tick();
        b_idle();
        b_p1(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        tick();
        checks++; if (b_O1 !== 16'h0000) begin failures++; $display("FAIL outreg_lat1 got %h exp %h", b_O1, 16'h0000); end
        b_idle();
        tick();
        checks++; if (b_O1 !== 16'h1234) begin failures++; $display("FAIL outreg_lat2 got %h exp %h", b_O1, 16'h1234); end
        b_p1(1'b1, 1'b0, 4'd13, 16'hDEAD, 2'b11);
        b_p2(1'b1, 1'b0, 4'd13, 16'hBEEF, 2'b11);
        tick();
        checks++; if (b_col !== 1'b1) begin failures++; $display("FAIL oor_equal_collision got %b exp 1", b_col); end
        b_p1(1'b1, 1'b0, 4'd12, 16'hDEAD, 2'b11);
        b_p2(1'b1, 1'b0, 4'd13, 16'hBEEF, 2'b11);
        tick();
        checks++; if (b_col !== 1'b0) begin failures++; $display("FAIL oor_diff_collision got %b exp 0", b_col); end
        b_idle();
        b_p1(1'b0, 1'b1, 4'd13, 16'h0, 2'b11);
        b_p2(1'b0, 1'b1, 4'd12, 16'h0, 2'b11);
        tick();
        tick();
        checks++; if (b_O1 !== 16'h0000) begin failures++; $display("FAIL oor_read13 got %h exp %h", b_O1, 16'h0000); end
        checks++; if (b_O2 !== 16'h0000) begin failures++; $display("FAIL oor_read12 got %h exp %h", b_O2, 16'h0000); end
        b_p1(1'b0, 1'b1, 4'd11, 16'h0, 2'b11);
        b_p2(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        tick();
        tick();
        checks++; if (b_O1 !== 16'hB0B0) begin failures++; $display("FAIL oor_word11_kept got %h exp %h", b_O1, 16'hB0B0); end
        checks++; if (b_O2 !== 16'h1234) begin failures++; $display("FAIL oor_word3_kept got %h exp %h", b_O2, 16'h1234); end
        b_idle();
    endtask

    task automatic test_reset_mid_clear;
        int n;
        a_idle();
        b_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (9) tick();
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL midclr_busy_step9 got %b exp 1", a_busy); end
        reset = 1'b1;
        tick();
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL midclr_busy_in_reset got %b exp 1", a_busy); end
        checks++; if (a_O1 !== 16'h0000) begin failures++; $display("FAIL midclr_a_O1_reset got %h exp %h", a_O1, 16'h0000); end
        checks++; if (b_O1 !== 16'h0000) begin failures++; $display("FAIL midclr_b_O1_reset got %h exp %h", b_O1, 16'h0000); end
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy && n < 40);
        checks++; if (n !== 16) begin failures++; $display("FAIL midclr_busy_cycles got %0d exp 16", n); end
        a_p1(1'b0, 1'b1, 4'd3, 16'h0, 2'b11);
        a_p2(1'b0, 1'b1, 4'd9, 16'h0, 2'b11);
        tick();
        checks++; if (a_O1 !== 16'h0000) begin failures++; $display("FAIL midclr_word3 got %h exp %h", a_O1, 16'h0000); end
        checks++; if (a_O2 !== 16'h0000) begin failures++; $display("FAIL midclr_word9 got %h exp %h", a_O2, 16'h0000); end
        a_idle();
    endtask

    initial begin
        test_reset();
        test_clear_busy();
        test_write_read();
        test_mask_merge();
        test_read_write_cross();
        test_no_collision();
        test_out_reg_range();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
